// File: rtl/hex_word_streamer_pkg.sv
// Shared types and constants for the hex word streamer.
//   hs_state_t : FSM state encoding (HS_IDLE=0, HS_HEX=1, HS_CR=2, HS_LF=3)
//   ASCII_CR / ASCII_LF : line terminator characters
//   idx_width(): width of the digit index register, at least one bit
package hex_word_streamer_pkg;

    typedef enum logic [1:0] {
        HS_IDLE = 2'd0,
        HS_HEX  = 2'd1,
        HS_CR   = 2'd2,
        HS_LF   = 2'd3
    } hs_state_t;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    function automatic int idx_width(input int nchars);
        return (nchars > 1) ? $clog2(nchars) : 1;
    endfunction

endpackage

// File: rtl/hex_word_streamer_if.sv
// Word-in / character-out bus of the hex word streamer.
//   word_in, word_valid, word_ready : word handshake (source -> streamer)
//   char_out, char_valid, char_ready : character handshake (streamer -> UART)
//   busy                             : a word is being printed
// Handshake rule for both channels: a transfer happens on a rising clock edge
// where valid and ready are both 1; the sender holds valid and its payload
// stable until that edge, and valid never depends combinationally on ready.
interface hex_word_streamer_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] word_in;
    logic             word_valid;
    logic             word_ready;
    logic [7:0]       char_out;
    logic             char_valid;
    logic             char_ready;
    logic             busy;

    modport master (
        output word_in, word_valid, char_ready,
        input  word_ready, char_out, char_valid, busy
    );

    modport slave (
        input  word_in, word_valid, char_ready,
        output word_ready, char_out, char_valid, busy
    );
endinterface

// File: rtl/hex_word_streamer_nibble_to_hex.sv
// nibble_to_hex: encodes one 4-bit value as an uppercase ASCII hex digit.
//   nibble : value 0..15
//   ascii  : "0"-"9" or "A"-"F"
module nibble_to_hex (
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);
    always_comb begin
        ascii = 8'h00;
        if (nibble < 4'd10) begin
            ascii = 8'h30 + {4'h0, nibble};
        end else begin
            // 8'h37 + 10 = "A"
            ascii = 8'h37 + {4'h0, nibble};
        end
    end
endmodule

// File: rtl/hex_word_streamer.sv
// hex_word_streamer: prints a WIDTH-bit word as ASCII hex, most-significant
// nibble first, optionally followed by CR LF.
//   clk, rst  : clock, asynchronous active-high reset
//   bus       : word/character handshakes (see hex_word_streamer_if)
//   state_dbg : current FSM state, for observation only
// WIDTH must be a multiple of 4 and at least 4.
module hex_word_streamer
    import hex_word_streamer_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter bit NEWLINE = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    hex_word_streamer_if.slave     bus,
    output hs_state_t              state_dbg
);
    localparam int NCHARS = WIDTH / 4;
    localparam int IDXW   = idx_width(NCHARS);

    hs_state_t        state;
    logic [IDXW-1:0]  idx;
    logic [WIDTH-1:0] word_q;
    logic [3:0]       nibble;
    logic [7:0]       digit;
    logic             xfer;

    // Outputs come only from registers, so char_ready/word_valid never reach them.
    assign bus.word_ready = (state == HS_IDLE);
    assign bus.busy       = (state != HS_IDLE);
    assign bus.char_valid = (state != HS_IDLE);
    assign state_dbg      = state;

    assign xfer   = bus.char_valid && bus.char_ready;
    assign nibble = word_q[4*idx +: 4];

    nibble_to_hex u_enc (
        .nibble (nibble),
        .ascii  (digit)
    );

    always_comb begin
        bus.char_out = 8'h00;
        case (state)
            HS_HEX:  bus.char_out = digit;
            HS_CR:   bus.char_out = ASCII_CR;
            HS_LF:   bus.char_out = ASCII_LF;
            default: bus.char_out = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= HS_IDLE;
            idx    <= '0;
            word_q <= '0;
        end else begin
            case (state)
                HS_IDLE: begin
                    if (bus.word_valid) begin
                        word_q <= bus.word_in;
                        idx    <= IDXW'(NCHARS - 1);
                        state  <= HS_HEX;
                    end
                end
                HS_HEX: begin
                    if (xfer) begin
                        // Exit at idx == 0 so idx never wraps.
                        if (idx != '0) begin
                            idx <= idx - 1'b1;
                        end else if (NEWLINE) begin
                            state <= HS_CR;
                        end else begin
                            state <= HS_IDLE;
                        end
                    end
                end
                HS_CR: begin
                    if (xfer) state <= HS_LF;
                end
                HS_LF: begin
                    if (xfer) state <= HS_IDLE;
                end
                default: state <= HS_IDLE;
            endcase
        end
    end
endmodule
